master_controller: RTL and testbench

Top-level sequencer for the coprocessor. It decodes command bytes arriving from the UART receiver and drives the shared `master_state`/`status` bus that selects which sub-controller owns the BRAM and UART. The sub-controllers are the write controller, the processing core and the read controller. Each transaction ends on the owning sub-controller's done pulse, or, while loading data, on a watchdog timeout. The block sits between `uart_rx` and the write/proc/read controllers.

---
 rtl/coproc_pkg.sv | 57 +++++
 rtl/master_controller_if.sv | 37 +++
 rtl/watchdog_counter.sv | 35 +++
 rtl/master_controller.sv | 106 ++++++++++
 tb/tb_master_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// ---------------------------------------------------------------------------
// coproc_pkg
// Shared definitions for the coprocessor: the master phase encoding seen on
// the master_state bus, UART command opcodes, status codes and a command
// decoder. The master controller and the write/proc/read controllers all
// import this package.
// ---------------------------------------------------------------------------
package coproc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        PROC  = 2'd3
    } master_state_t;

    localparam logic [7:0] CMD_WRITE_A   = 8'h01;
    localparam logic [7:0] CMD_WRITE_B   = 8'h02;
    localparam logic [7:0] CMD_READ_A    = 8'h03;
    localparam logic [7:0] CMD_READ_B    = 8'h04;
    localparam logic [7:0] CMD_PROC_SUM  = 8'h05;
    localparam logic [7:0] CMD_PROC_AVG  = 8'h06;
    localparam logic [7:0] CMD_PROC_DIST = 8'h07;

    localparam logic [2:0] STATUS_NONE  = 3'd0;
    localparam logic [2:0] STATUS_VEC_A = 3'd1;
    localparam logic [2:0] STATUS_VEC_B = 3'd2;
    localparam logic [2:0] STATUS_SUM   = 3'd3;
    localparam logic [2:0] STATUS_AVG   = 3'd4;
    localparam logic [2:0] STATUS_DIST  = 3'd5;

    // Result of decoding one command byte received while IDLE.
    typedef struct packed {
        logic          valid;
        master_state_t next_state;
        logic [2:0]    status;
    } cmd_decode_t;

    function automatic cmd_decode_t decode_cmd(input logic [7:0] cmd);
        cmd_decode_t d;
        d.valid      = 1'b1;
        d.next_state = IDLE;
        d.status     = STATUS_NONE;
        case (cmd)
            CMD_WRITE_A:   begin d.next_state = WRITE; d.status = STATUS_VEC_A; end
            CMD_WRITE_B:   begin d.next_state = WRITE; d.status = STATUS_VEC_B; end
            CMD_READ_A:    begin d.next_state = READ;  d.status = STATUS_VEC_A; end
            CMD_READ_B:    begin d.next_state = READ;  d.status = STATUS_VEC_B; end
            CMD_PROC_SUM:  begin d.next_state = PROC;  d.status = STATUS_SUM;   end
            CMD_PROC_AVG:  begin d.next_state = PROC;  d.status = STATUS_AVG;   end
            CMD_PROC_DIST: begin d.next_state = PROC;  d.status = STATUS_DIST;  end
            default:       d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/master_controller_if.sv
// ---------------------------------------------------------------------------
// master_controller_if
// Bundle between the master controller, the UART receiver and the
// sub-controllers.
//   rx_data/rx_ready          : byte from UART receiver (pulse qualifies data)
//   write_done/proc_done/read_done : one-cycle completion pulses
//   master_state/status       : phase owner and operand/operation select
//   busy                      : master_state != IDLE
//   cmd_error/timeout_err     : one-cycle error pulses
//
// Handshake: there is no back-pressure on this bus. rx_ready is a one-cycle
// valid strobe and rx_data is only meaningful in that cycle; the master
// always consumes (or deliberately drops) it. Done inputs and error outputs
// are likewise single-cycle strobes with no ready/acknowledge.
// ---------------------------------------------------------------------------
interface master_controller_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       write_done;
    logic       proc_done;
    logic       read_done;
    logic [1:0] master_state;
    logic [2:0] status;
    logic       busy;
    logic       cmd_error;
    logic       timeout_err;

    modport master (
        input  rx_data, rx_ready, write_done, proc_done, read_done,
        output master_state, status, busy, cmd_error, timeout_err
    );

    modport slave (
        output rx_data, rx_ready, write_done, proc_done, read_done,
        input  master_state, status, busy, cmd_error, timeout_err
    );
endinterface

// File: rtl/watchdog_counter.sv
// ---------------------------------------------------------------------------
// watchdog_counter
// Inactivity counter for the WRITE phase.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count one per cycle
//   expired  : combinational, high while count == TIMEOUT_CYCLES-1
// The counter saturates at all-ones rather than wrapping.
// ---------------------------------------------------------------------------
module watchdog_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);
endmodule

// File: rtl/master_controller.sv
// ---------------------------------------------------------------------------
// master_controller
// Top-level sequencer: decodes UART command bytes while IDLE and hands the
// BRAM/UART to the write controller, processing core or read controller via
// master_state/status. PROC always continues into READ so the result of the
// same operation is streamed back. WRITE is guarded by a watchdog.
//   clk, rst : clock, async active-high reset
//   bus      : master_controller_if.master (see interface for signals)
// master_state is the FSM state register itself and doubles as its debug view.
// ---------------------------------------------------------------------------
module master_controller
    import coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    master_controller_if.master  bus
);
    master_state_t state_q, state_d;
    logic [2:0]    status_q, status_d;
    logic          cmd_error_q, cmd_error_d;
    logic          timeout_err_q, timeout_err_d;
    cmd_decode_t   dec;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    // Counter sits at zero outside WRITE, so entering WRITE starts from 0.
    // Any byte in WRITE counts as activity and restarts the count.
    assign wd_en  = (state_q == WRITE);
    assign wd_clr = (state_q != WRITE) || bus.rx_ready;

    watchdog_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            status_q      <= STATUS_NONE;
            cmd_error_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            cmd_error_q   <= cmd_error_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        cmd_error_d   = 1'b0;
        timeout_err_d = 1'b0;
        dec           = decode_cmd(bus.rx_data);

        case (state_q)
            IDLE: begin
                if (bus.rx_ready) begin
                    if (dec.valid) begin
                        state_d  = dec.next_state;
                        status_d = dec.status;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Completion beats the watchdog; a byte arriving on the
                // expiry cycle counts as activity and also cancels the abort.
                if (bus.write_done) begin
                    state_d = IDLE;
                end else if (wd_expired && !bus.rx_ready) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            PROC: begin
                if (bus.proc_done) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.read_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.master_state = state_q;
    assign bus.status       = status_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.cmd_error    = cmd_error_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_master_controller.sv
module tb_master_controller;
    localparam int unsigned TMO = 100;

    logic clk;
    logic rst;
    master_controller_if bus();

    master_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic       rx_ready;
        logic [7:0] rx_data;
        logic       wd;
        logic       pd;
        logic       rd;
        logic [1:0] st;
        logic [2:0] stat;
        logic       err;
        logic       tout;
    } vec_t;

    vec_t vec_q[$];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] stat,
                             input logic err, input logic tout);
        check({tag, " state"},  32'(bus.master_state), 32'(st));
        check({tag, " status"}, 32'(bus.status),       32'(stat));
        check({tag, " busy"},   32'(bus.busy),         32'(st != 2'd0));
        check({tag, " cmd_error"},   32'(bus.cmd_error),   32'(err));
        check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(tout));
    endtask

    task automatic add_vec(input logic rr, input logic [7:0] d, input logic wd, input logic pd,
                           input logic rd, input logic [1:0] st, input logic [2:0] stat,
                           input logic err, input logic tout);
        vec_t v;
        v.rx_ready = rr; v.rx_data = d; v.wd = wd; v.pd = pd; v.rd = rd;
        v.st = st; v.stat = stat; v.err = err; v.tout = tout;
        vec_q.push_back(v);
    endtask

    // ---------------- driver ----------------
    // One clock cycle: inputs set at negedge, held over posedge, removed just after.
    task automatic drive(input logic rr, input logic [7:0] d, input logic wd,
                         input logic pd, input logic rd);
        @(negedge clk);
        bus.rx_ready   = rr;
        bus.rx_data    = d;
        bus.write_done = wd;
        bus.proc_done  = pd;
        bus.read_done  = rd;
        @(posedge clk);
        #1;
        bus.rx_ready   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.write_done = 1'b0;
        bus.proc_done  = 1'b0;
        bus.read_done  = 1'b0;
    endtask

    task automatic idle_cycles(input int n, output logic saw_tout, output logic left_write);
        saw_tout   = 1'b0;
        left_write = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (bus.timeout_err) saw_tout = 1'b1;
            if (bus.master_state != 2'd1) left_write = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic saw_tout;
        logic left_write;
        n_cmp  = 0;
        n_fail = 0;
        bus.rx_ready = 1'b0; bus.rx_data = 8'h00;
        bus.write_done = 1'b0; bus.proc_done = 1'b0; bus.read_done = 1'b0;
        rst = 1'b1;
        #1;
        check_all("reset", 2'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //       rr  data   wd pd rd   st  stat err tout
        add_vec(1, 8'h01, 0, 0, 0, 2'd1, 3'd1, 0, 0);  // write A
        add_vec(0, 8'h00, 0, 0, 0, 2'd1, 3'd1, 0, 0);
        add_vec(0, 8'h00, 1, 0, 0, 2'd0, 3'd1, 0, 0);  // write_done
        add_vec(0, 8'h00, 1, 0, 0, 2'd0, 3'd1, 0, 0);  // stray write_done in IDLE
        add_vec(1, 8'h06, 0, 0, 0, 2'd3, 3'd4, 0, 0);  // proc avg
        add_vec(0, 8'h00, 0, 0, 1, 2'd3, 3'd4, 0, 0);  // stray read_done in PROC
        add_vec(1, 8'h01, 0, 0, 0, 2'd3, 3'd4, 0, 0);  // byte in PROC ignored
        add_vec(0, 8'h00, 0, 1, 0, 2'd2, 3'd4, 0, 0);  // proc_done -> READ
        add_vec(1, 8'h01, 0, 0, 0, 2'd2, 3'd4, 0, 0);  // byte in READ ignored
        add_vec(0, 8'h00, 0, 1, 0, 2'd2, 3'd4, 0, 0);  // stray proc_done in READ
        add_vec(0, 8'h00, 0, 0, 1, 2'd0, 3'd4, 0, 0);  // read_done
        add_vec(1, 8'h5A, 0, 0, 0, 2'd0, 3'd4, 1, 0);  // unknown command
        add_vec(0, 8'h00, 0, 0, 0, 2'd0, 3'd4, 0, 0);  // error is one cycle
        add_vec(1, 8'h00, 0, 0, 0, 2'd0, 3'd4, 1, 0);
        add_vec(1, 8'h08, 0, 0, 0, 2'd0, 3'd4, 1, 0);
        add_vec(1, 8'hFF, 0, 0, 0, 2'd0, 3'd4, 1, 0);
        add_vec(1, 8'h04, 0, 0, 0, 2'd2, 3'd2, 0, 0);  // read B
        add_vec(1, 8'h03, 0, 0, 1, 2'd0, 3'd2, 0, 0);  // cmd with read_done dropped
        add_vec(0, 8'h00, 0, 0, 0, 2'd0, 3'd2, 0, 0);
        add_vec(1, 8'h07, 0, 0, 0, 2'd3, 3'd5, 0, 0);  // proc dist
        add_vec(0, 8'h00, 0, 1, 0, 2'd2, 3'd5, 0, 0);
        add_vec(0, 8'h00, 0, 0, 1, 2'd0, 3'd5, 0, 0);
        add_vec(1, 8'h05, 0, 0, 0, 2'd3, 3'd3, 0, 0);  // proc sum
        add_vec(0, 8'h00, 0, 1, 0, 2'd2, 3'd3, 0, 0);
        add_vec(0, 8'h00, 0, 0, 1, 2'd0, 3'd3, 0, 0);
        add_vec(1, 8'h02, 0, 0, 0, 2'd1, 3'd2, 0, 0);  // write B
        add_vec(1, 8'h04, 0, 0, 0, 2'd1, 3'd2, 0, 0);  // payload, not a command
        add_vec(1, 8'h5A, 0, 0, 0, 2'd1, 3'd2, 0, 0);  // payload, no cmd_error
        add_vec(0, 8'h00, 0, 0, 1, 2'd1, 3'd2, 0, 0);  // stray read_done in WRITE
        add_vec(0, 8'h00, 1, 0, 0, 2'd0, 3'd2, 0, 0);

        foreach (vec_q[i]) begin
            drive(vec_q[i].rx_ready, vec_q[i].rx_data, vec_q[i].wd, vec_q[i].pd, vec_q[i].rd);
            check_all($sformatf("vec%0d", i), vec_q[i].st, vec_q[i].stat, vec_q[i].err, vec_q[i].tout);
        end

        // Watchdog abort: WRITE lasts exactly TMO cycles with no activity.
        drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        check_all("tmo accept", 2'd1, 3'd2, 1'b0, 1'b0);
        idle_cycles(TMO - 1, saw_tout, left_write);
        check("tmo early abort", 32'(saw_tout), 32'd0);
        check("tmo early exit", 32'(left_write), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_all("tmo fire", 2'd0, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_all("tmo after", 2'd0, 3'd2, 1'b0, 1'b0);

        // rx_ready on the expiry cycle wins; write_done on expiry is normal.
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_cycles(TMO - 1, saw_tout, left_write);
        check("edge rx early", 32'(saw_tout | left_write), 32'd0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check_all("edge rx wins", 2'd1, 3'd1, 1'b0, 1'b0);
        idle_cycles(TMO - 1, saw_tout, left_write);
        check("edge wd early", 32'(saw_tout | left_write), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_all("edge done wins", 2'd0, 3'd1, 1'b0, 1'b0);

        // Bytes every 90 cycles keep WRITE alive.
        drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            idle_cycles(89, saw_tout, left_write);
            check($sformatf("keepalive%0d", r), 32'(saw_tout | left_write), 32'd0);
            drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
            check_all($sformatf("keepalive%0d byte", r), 2'd1, 3'd2, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_all("keepalive done", 2'd0, 3'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-READ, away from any clock edge.
        drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        check_all("pre-rst read", 2'd2, 3'd1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async rst read", 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset clears a live cmd_error pulse.
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check_all("pre-rst err", 2'd0, 3'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async rst err", 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        check_all("post-rst read", 2'd2, 3'd1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_all("post-rst done", 2'd0, 3'd1, 1'b0, 1'b0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
